// File: rtl/switch_pkg.sv
// State encodings and default limits shared by the switch conditioning blocks.
package switch_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_CHECK_HIGH  = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_CHECK_LOW   = 2'd3
    } sw_state_e;

    // 10 ms and 1 s at a 25 MHz system clock
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT   = 250000;
    localparam int unsigned DEFAULT_LONG_PRESS_LIMIT = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/switch_debounce_edge.sv
// Debounces one raw mechanical switch into a clean level plus press/release strobes.
// Optional long-press strobe is built only when SWITCH_LONG_PRESS_EN is defined.
module switch_debounce_edge #(
    parameter int unsigned DEBOUNCE_LIMIT   = switch_pkg::DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned LONG_PRESS_LIMIT = switch_pkg::DEFAULT_LONG_PRESS_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press
);

    import switch_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_LIMIT < 1 || LONG_PRESS_LIMIT < 1) begin : g_bad_limits
        $error("switch_debounce_edge: DEBOUNCE_LIMIT and LONG_PRESS_LIMIT must be >= 1");
    end

    logic       sw_sync;
    sw_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       switch_q, switch_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     (i_Switch),
        .q     (sw_sync)
    );

    // A new level is accepted only after the counter has seen it for DEBOUNCE_LIMIT extra cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        switch_d  = switch_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_STABLE_LOW: begin
                if (sw_sync) begin
                    state_d = ST_CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHECK_HIGH: begin
                if (!sw_sync) begin
                    state_d = ST_STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_STABLE_HIGH;
                    switch_d = 1'b1;
                    press_d  = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE_HIGH: begin
                if (!sw_sync) begin
                    state_d = ST_CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHECK_LOW: begin
                if (sw_sync) begin
                    state_d = ST_STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_STABLE_LOW;
                    switch_d  = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_STABLE_LOW;
            cnt_q     <= '0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            switch_q  <= switch_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_Switch  = switch_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;

`ifdef SWITCH_LONG_PRESS_EN
    localparam int unsigned       LONG_W   = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_PRESS_LIMIT);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_press_q, long_press_d;

    // Saturating at LONG_MAX makes the strobe fire once per press; CHECK_LOW bounces keep the count.
    always_comb begin
        long_cnt_d   = long_cnt_q;
        long_press_d = 1'b0;
        if (press_d) begin
            long_cnt_d = '0;
        end else if (state_q == ST_STABLE_HIGH && long_cnt_q != LONG_MAX) begin
            long_cnt_d   = long_cnt_q + 1'b1;
            long_press_d = (long_cnt_d == LONG_MAX);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_press_d;
        end
    end

    assign o_Long_Press = long_press_q;
`else
    assign o_Long_Press = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_edge.sv
// Self-checking bench for switch_debounce_edge (DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10).
module tb_switch_debounce_edge;

    localparam int unsigned L   = 4;
    localparam int unsigned LP  = 10;
    localparam int unsigned LAT = L + 3;

`ifdef SWITCH_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic i_Clk    = 1'b0;
    logic i_Rst_L  = 1'b0;
    logic i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release, o_Long_Press;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the accepted level flips once the synchronized input has
    // disagreed with it for L+1 consecutive sampled edges.
    logic m_d0, m_d1;
    logic m_level, m_press, m_release, m_long;
    int   m_run;
    int   m_high;

    switch_debounce_edge #(
        .DEBOUNCE_LIMIT   (L),
        .LONG_PRESS_LIMIT (LP)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Switch     (i_Switch),
        .o_Switch     (o_Switch),
        .o_Press      (o_Press),
        .o_Release    (o_Release),
        .o_Long_Press (o_Long_Press)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic void model_reset();
        m_d0 = 0; m_d1 = 0;
        m_level = 0; m_press = 0; m_release = 0; m_long = 0;
        m_run = 0; m_high = 0;
    endfunction

    function automatic void model_edge(input logic val);
        logic seen;
        seen = m_d1;
        m_d1 = m_d0;
        m_d0 = val;
        m_press = 0; m_release = 0; m_long = 0;
        if (LONG_EN && m_level && m_run == 0 && m_high < int'(LP)) begin
            m_high++;
            if (m_high == int'(LP)) m_long = 1;
        end
        if (seen != m_level) begin
            m_run++;
            if (m_run == int'(L) + 1) begin
                m_level   = seen;
                m_run     = 0;
                m_high    = 0;
                m_press   = seen;
                m_release = !seen;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [3:0] model_vec();
        return {m_level, m_press, m_release, m_long};
    endfunction

    // Drive the input just after the previous edge, clock once, sample 1 ns after the edge.
    task automatic tick(input logic val);
        i_Switch = val;
        @(posedge i_Clk);
        model_edge(val);
        #1;
    endtask

    task automatic release_reset();
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
    endtask

    task automatic test_reset();
        i_Switch = 1'b1;
        model_reset();
        repeat (3) @(posedge i_Clk);
        #1;
        n_checks++;
        if ({o_Switch, o_Press, o_Release, o_Long_Press} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got %b expected 0000", {o_Switch, o_Press, o_Release, o_Long_Press});
        end
        i_Switch = 1'b0;
        release_reset();
    endtask

    task automatic test_clean_step();
        int press_edge = -1;
        int presses = 0;
        int releases = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b1);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL clean_step edge %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Press) begin presses++; press_edge = k; end
            if (o_Release) releases++;
        end
        n_checks++;
        if (presses != 1 || press_edge != int'(LAT) || releases != 0) begin
            n_fail++;
            $display("[TB] FAIL clean_step_latency: got press edge %0d (%0d presses, %0d releases) expected edge %0d, 1 press, 0 releases",
                     press_edge, presses, releases, LAT);
        end
    endtask

    task automatic test_release();
        int rel_edge = -1;
        int releases = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL release edge %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Release) begin releases++; rel_edge = k; end
        end
        n_checks++;
        if (releases != 1 || rel_edge != int'(LAT) || o_Switch !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL release_latency: got edge %0d (%0d pulses, level %b) expected edge %0d, 1 pulse, level 0",
                     rel_edge, releases, o_Switch, LAT);
        end
    endtask

    task automatic test_bounce();
        logic pattern[$];
        int press_edge = -1;
        int presses = 0;
        pattern = '{1, 1, 1, 0, 0};
        for (int k = 0; k < 14; k++) pattern.push_back(1'b1);
        for (int k = 0; k < pattern.size(); k++) begin
            tick(pattern[k]);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL bounce step %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Press) begin presses++; press_edge = k - 4; end
        end
        n_checks++;
        if (presses != 1 || press_edge != int'(LAT)) begin
            n_fail++;
            $display("[TB] FAIL bounce_latency: got %0d presses at edge %0d after final rise, expected 1 at edge %0d",
                     presses, press_edge, LAT);
        end
        repeat (10) tick(1'b0);
    endtask

    task automatic test_glitch();
        logic pattern[$];
        int activity = 0;
        pattern = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < pattern.size(); k++) begin
            tick(pattern[k]);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL glitch step %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Switch || o_Press || o_Release) activity++;
        end
        n_checks++;
        if (activity != 0) begin
            n_fail++;
            $display("[TB] FAIL glitch_quiet: got %0d active cycles expected 0", activity);
        end
    endtask

    task automatic test_reset_mid_count();
        int press_edge = -1;
        repeat (12) tick(1'b1);
        i_Rst_L = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({o_Switch, o_Press, o_Release, o_Long_Press} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL async_reset_high: got %b expected 0000", {o_Switch, o_Press, o_Release, o_Long_Press});
        end
        release_reset();
        repeat (6) tick(1'b0);
        for (int k = 1; k <= 5; k++) tick(1'b1);
        i_Rst_L = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({o_Switch, o_Press, o_Release, o_Long_Press} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_count: got %b expected 0000", {o_Switch, o_Press, o_Release, o_Long_Press});
        end
        release_reset();
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL post_reset edge %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Press) press_edge = k;
        end
        n_checks++;
        if (press_edge != int'(LAT)) begin
            n_fail++;
            $display("[TB] FAIL post_reset_latency: got press edge %0d expected %0d", press_edge, LAT);
        end
    endtask

    task automatic test_long_press();
        int press_edge = -1;
        int long_edge = -1;
        int longs = 0;
        i_Rst_L = 1'b0;
        model_reset();
        release_reset();
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1);
            n_checks++;
            if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                n_fail++;
                $display("[TB] FAIL long_press edge %0d: got %b expected %b", k,
                         {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
            end
            if (o_Press) press_edge = k;
            if (o_Long_Press) begin longs++; long_edge = k; end
        end
        n_checks++;
`ifdef SWITCH_LONG_PRESS_EN
        if (longs != 1 || long_edge != press_edge + int'(LP)) begin
            n_fail++;
            $display("[TB] FAIL long_press_timing: got %0d pulses at edge %0d expected 1 at edge %0d",
                     longs, long_edge, press_edge + int'(LP));
        end
`else
        if (longs != 0) begin
            n_fail++;
            $display("[TB] FAIL long_press_off: got %0d pulses (last edge %0d) expected 0", longs, long_edge);
        end
`endif
        repeat (10) tick(1'b0);
    endtask

    task automatic test_random();
        int both = 0;
        for (int seg = 0; seg < 150; seg++) begin
            logic val;
            int len;
            val = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                tick(val);
                n_checks++;
                if ({o_Switch, o_Press, o_Release, o_Long_Press} !== model_vec()) begin
                    n_fail++;
                    $display("[TB] FAIL random seg %0d: got %b expected %b", seg,
                             {o_Switch, o_Press, o_Release, o_Long_Press}, model_vec());
                end
                if (o_Press && o_Release) both++;
            end
        end
        n_checks++;
        if (both != 0) begin
            n_fail++;
            $display("[TB] FAIL random_exclusive: got %0d cycles with both strobes expected 0", both);
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_mid_count();
        test_long_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
